// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction timer statistics path.
// Holds the display-selection enum, default parameter values, common
// widths and small helper functions used by reaction_stats and hist_ring.
package reaction_pkg;

  typedef enum logic [1:0] {
    LAST  = 2'd0,
    BEST  = 2'd1,
    AVG   = 2'd2,
    COUNT = 2'd3
  } disp_sel_e;

  localparam int MAX_MS_DEFAULT     = 999;
  localparam int HIST_DEPTH_DEFAULT = 4;
  localparam int MS_W               = 13;
  localparam int CNT_W              = 8;

  // Display selection order: LAST -> BEST -> AVG -> COUNT -> LAST.
  function automatic disp_sel_e disp_sel_step(input disp_sel_e cur);
    disp_sel_e nxt;
    case (cur)
      LAST:    nxt = BEST;
      BEST:    nxt = AVG;
      AVG:     nxt = COUNT;
      COUNT:   nxt = LAST;
      default: nxt = LAST;
    endcase
    return nxt;
  endfunction

  // Increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hist_ring.sv
// History ring buffer for the running average of accepted trials.
// Keeps the last HIST_DEPTH accepted values, a wrapping write pointer, a
// saturating fill count and an incrementally maintained sum. The average
// and its valid flag are registered alongside the sum so they appear with
// the same one-cycle latency as the other statistics.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   i_clear       erase history (same effect as reset on this block)
//   i_wr_en       write one accepted value
//   i_wr_data     value written (already known to be <= MAX_MS)
//   o_avg_ms      sum >> log2(HIST_DEPTH), 0 until the buffer is full
//   o_avg_valid   buffer has been filled since the last clear/reset
module hist_ring
  import reaction_pkg::*;
#(
  parameter int HIST_DEPTH = HIST_DEPTH_DEFAULT,
  parameter int SUM_W      = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_wr_en,
  input  logic [SUM_W-1:0] i_wr_data,
  output logic [MS_W-1:0]  o_avg_ms,
  output logic             o_avg_valid
);

  localparam int PTR_W  = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam int FILL_W = $clog2(HIST_DEPTH + 1);
  localparam int SHIFT  = $clog2(HIST_DEPTH);

  logic [SUM_W-1:0]  r_mem [HIST_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [FILL_W-1:0] r_fill;
  logic [SUM_W-1:0]  r_sum;
  logic [MS_W-1:0]   r_avg;
  logic              r_avg_valid;

  logic [PTR_W-1:0]  w_wr_ptr_next;
  logic [FILL_W-1:0] w_fill_next;
  logic [SUM_W-1:0]  w_evicted;
  logic [SUM_W-1:0]  w_sum_next;
  logic              w_full_next;
  logic [MS_W-1:0]   w_avg_next;

  // Next-state values for a write: the entry under the pointer is only
  // subtracted once the buffer is full, so an unfilled slot counts as 0.
  always_comb begin
    w_evicted     = '0;
    w_wr_ptr_next = r_wr_ptr;
    w_fill_next   = r_fill;
    w_sum_next    = r_sum;
    w_full_next   = 1'b0;
    w_avg_next    = '0;

    if (r_fill == FILL_W'(HIST_DEPTH)) begin
      w_evicted   = r_mem[r_wr_ptr];
      w_fill_next = r_fill;
    end else begin
      w_evicted   = '0;
      w_fill_next = r_fill + FILL_W'(1);
    end

    if (r_wr_ptr == PTR_W'(HIST_DEPTH - 1)) begin
      w_wr_ptr_next = '0;
    end else begin
      w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
    end

    w_sum_next  = r_sum + i_wr_data - w_evicted;
    w_full_next = (w_fill_next == FILL_W'(HIST_DEPTH));

    if (w_full_next) begin
      w_avg_next = MS_W'(w_sum_next >> SHIFT);
    end else begin
      w_avg_next = '0;
    end
  end

  // History storage, pointer, fill count, sum and registered average.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_sum       <= '0;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
    end else if (i_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
      r_wr_ptr        <= w_wr_ptr_next;
      r_fill          <= w_fill_next;
      r_sum           <= w_sum_next;
      r_avg           <= w_avg_next;
      r_avg_valid     <= w_full_next;
    end else begin
      r_wr_ptr    <= r_wr_ptr;
      r_fill      <= r_fill;
      r_sum       <= r_sum;
      r_avg       <= r_avg;
      r_avg_valid <= r_avg_valid;
    end
  end

  assign o_avg_ms    = r_avg;
  assign o_avg_valid = r_avg_valid;

endmodule

// File: rtl/reaction_stats.sv
// Reaction-time statistics: last, best and running average of accepted
// trials, accepted/rejected trial counters, a new-best pulse and a
// four-way display selector feeding the BCD/display path.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   result_valid/_ms/_err    finished-trial strobe, time (ms), false start
//   clear_stats              erase all statistics (display selection kept)
//   sel_next                 advance display selection
//   disp_sel, disp_ms        current selection and its value
//   last_ms, best_ms, avg_ms statistics; best_valid, avg_valid flags
//   trial_cnt, fault_cnt     saturating accepted / rejected counters
//   new_best                 one-cycle pulse on a strictly better trial
module reaction_stats
  import reaction_pkg::*;
#(
  parameter int MAX_MS     = MAX_MS_DEFAULT,
  parameter int HIST_DEPTH = HIST_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              result_valid,
  input  logic [MS_W-1:0]   result_ms,
  input  logic              result_err,
  input  logic              clear_stats,
  input  logic              sel_next,
  output logic [1:0]        disp_sel,
  output logic [MS_W-1:0]   disp_ms,
  output logic [MS_W-1:0]   last_ms,
  output logic [MS_W-1:0]   best_ms,
  output logic [MS_W-1:0]   avg_ms,
  output logic              best_valid,
  output logic              avg_valid,
  output logic [CNT_W-1:0]  trial_cnt,
  output logic [CNT_W-1:0]  fault_cnt,
  output logic              new_best
);

  localparam int SUM_W = $clog2(MAX_MS * HIST_DEPTH + 1);

  disp_sel_e         r_disp_sel;
  disp_sel_e         w_disp_sel_next;
  logic [MS_W-1:0]   r_last;
  logic [MS_W-1:0]   r_best;
  logic              r_best_valid;
  logic [CNT_W-1:0]  r_trial_cnt;
  logic [CNT_W-1:0]  r_fault_cnt;
  logic              r_new_best;

  logic              w_accept;
  logic              w_reject;
  logic              w_better;
  logic [SUM_W-1:0]  w_hist_data;
  logic              w_hist_wr;

  // Trial classification; clear_stats suppresses the history write so the
  // clear wins over a coincident result.
  always_comb begin
    w_accept    = result_valid & ~result_err & (result_ms <= MS_W'(MAX_MS));
    w_reject    = result_valid & ~w_accept;
    w_better    = ~r_best_valid | (result_ms < r_best);
    w_hist_data = SUM_W'(result_ms);
    w_hist_wr   = w_accept & ~clear_stats;
  end

  // Last/best/counter registers and the new-best pulse.
  always_ff @(posedge clk) begin
    if (reset || clear_stats) begin
      r_last       <= '0;
      r_best       <= '0;
      r_best_valid <= 1'b0;
      r_trial_cnt  <= '0;
      r_fault_cnt  <= '0;
      r_new_best   <= 1'b0;
    end else if (w_accept) begin
      r_last      <= result_ms;
      r_trial_cnt <= sat_inc(r_trial_cnt);
      r_fault_cnt <= r_fault_cnt;
      if (w_better) begin
        r_best       <= result_ms;
        r_best_valid <= 1'b1;
        r_new_best   <= 1'b1;
      end else begin
        r_best       <= r_best;
        r_best_valid <= r_best_valid;
        r_new_best   <= 1'b0;
      end
    end else if (w_reject) begin
      r_fault_cnt <= sat_inc(r_fault_cnt);
      r_new_best  <= 1'b0;
    end else begin
      r_new_best  <= 1'b0;
    end
  end

  // Display selection state register; clear_stats does not touch it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp_sel <= LAST;
    end else begin
      r_disp_sel <= w_disp_sel_next;
    end
  end

  // Display selection next state: one step per sel_next pulse.
  always_comb begin
    w_disp_sel_next = r_disp_sel;
    if (sel_next) begin
      w_disp_sel_next = disp_sel_step(r_disp_sel);
    end else begin
      w_disp_sel_next = r_disp_sel;
    end
  end

  // Display value multiplexer, driven only from registers.
  always_comb begin
    disp_ms = '0;
    case (r_disp_sel)
      LAST:    disp_ms = r_last;
      BEST:    disp_ms = r_best;
      AVG:     disp_ms = avg_ms;
      COUNT:   disp_ms = {5'b0, r_trial_cnt};
      default: disp_ms = '0;
    endcase
  end

  hist_ring #(
    .HIST_DEPTH (HIST_DEPTH),
    .SUM_W      (SUM_W)
  ) u_hist_ring (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (clear_stats),
    .i_wr_en     (w_hist_wr),
    .i_wr_data   (w_hist_data),
    .o_avg_ms    (avg_ms),
    .o_avg_valid (avg_valid)
  );

  assign disp_sel   = r_disp_sel;
  assign last_ms    = r_last;
  assign best_ms    = r_best;
  assign best_valid = r_best_valid;
  assign trial_cnt  = r_trial_cnt;
  assign fault_cnt  = r_fault_cnt;
  assign new_best   = r_new_best;

endmodule

// File: tb/tb_reaction_stats.sv
// Self-checking bench for reaction_stats: directed scenarios followed by
// random trials, all compared against a list-based reference model.
module tb_reaction_stats;

  logic        clk = 1'b0;
  logic        reset;
  logic        result_valid;
  logic [12:0] result_ms;
  logic        result_err;
  logic        clear_stats;
  logic        sel_next;
  logic [1:0]  disp_sel;
  logic [12:0] disp_ms;
  logic [12:0] last_ms;
  logic [12:0] best_ms;
  logic [12:0] avg_ms;
  logic        best_valid;
  logic        avg_valid;
  logic [7:0]  trial_cnt;
  logic [7:0]  fault_cnt;
  logic        new_best;

  reaction_stats dut (
    .clk          (clk),
    .reset        (reset),
    .result_valid (result_valid),
    .result_ms    (result_ms),
    .result_err   (result_err),
    .clear_stats  (clear_stats),
    .sel_next     (sel_next),
    .disp_sel     (disp_sel),
    .disp_ms      (disp_ms),
    .last_ms      (last_ms),
    .best_ms      (best_ms),
    .avg_ms       (avg_ms),
    .best_valid   (best_valid),
    .avg_valid    (avg_valid),
    .trial_cnt    (trial_cnt),
    .fault_cnt    (fault_cnt),
    .new_best     (new_best)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int step_no  = 0;

  // Reference model: plain statistics over the list of accepted trials.
  int m_last, m_best, m_trial, m_fault, m_sel;
  bit m_bv, m_nb;
  int m_hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s (step %0d): observed=%0d expected=%0d", tag, step_no, obs, exp);
    end
  endtask

  function automatic void model_clear();
    m_last = 0; m_best = 0; m_bv = 0; m_trial = 0; m_fault = 0;
    m_hist.delete();
  endfunction

  function automatic int model_avg();
    int s;
    s = 0;
    if (m_hist.size() != 4) return 0;
    foreach (m_hist[i]) s += m_hist[i];
    return s / 4;
  endfunction

  function automatic void model_update(bit rst, bit v, int ms, bit err, bit clr, bit sel);
    m_nb = 0;
    if (rst) begin
      model_clear();
      m_sel = 0;
    end else begin
      if (clr) begin
        model_clear();
      end else if (v) begin
        if (!err && ms <= 999) begin
          m_last = ms;
          if (m_trial < 255) m_trial++;
          if (!m_bv || ms < m_best) begin
            m_best = ms; m_bv = 1; m_nb = 1;
          end
          m_hist.push_back(ms);
          if (m_hist.size() > 4) void'(m_hist.pop_front());
        end else if (m_fault < 255) begin
          m_fault++;
        end
      end
      if (sel) m_sel = (m_sel + 1) % 4;
    end
  endfunction

  task automatic check_all();
    int exp_disp;
    case (m_sel)
      0: exp_disp = m_last;
      1: exp_disp = m_best;
      2: exp_disp = model_avg();
      default: exp_disp = m_trial;
    endcase
    chk("last_ms",    32'(last_ms),    32'(m_last));
    chk("best_ms",    32'(best_ms),    32'(m_best));
    chk("best_valid", 32'(best_valid), 32'(m_bv));
    chk("avg_ms",     32'(avg_ms),     32'(model_avg()));
    chk("avg_valid",  32'(avg_valid),  32'(m_hist.size() == 4));
    chk("trial_cnt",  32'(trial_cnt),  32'(m_trial));
    chk("fault_cnt",  32'(fault_cnt),  32'(m_fault));
    chk("new_best",   32'(new_best),   32'(m_nb));
    chk("disp_sel",   32'(disp_sel),   32'(m_sel));
    chk("disp_ms",    32'(disp_ms),    32'(exp_disp));
  endtask

  // One clock cycle: drive at negedge, check 1 time unit after posedge.
  task automatic step(input bit rst, input bit v, input int ms, input bit err,
                      input bit clr, input bit sel);
    @(negedge clk);
    reset = rst; result_valid = v; result_ms = 13'(ms); result_err = err;
    clear_stats = clr; sel_next = sel;
    @(posedge clk);
    #1;
    reset = 1'b0; result_valid = 1'b0; result_ms = 13'd0; result_err = 1'b0;
    clear_stats = 1'b0; sel_next = 1'b0;
    step_no++;
    model_update(rst, v, ms, err, clr, sel);
    check_all();
  endtask

  task automatic trial(input int ms);
    step(1'b0, 1'b1, ms, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    step(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int ms, r;
    bit v, err, clr, sel, rst;
    reset = 1'b1; result_valid = 1'b0; result_ms = 13'd0; result_err = 1'b0;
    clear_stats = 1'b0; sel_next = 1'b0;
    m_sel = 0; m_nb = 0;
    model_clear();

    // Reset, with a result presented during reset that must be dropped.
    step(1'b1, 1'b1, 123, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("rst_trial", 32'(trial_cnt), 32'd0);
    chk("rst_sel",   32'(disp_sel),  32'd0);

    // Three trials: new_best after 250 and 180 only.
    trial(250); chk("t250_nb", 32'(new_best), 32'd1);
    trial(180); chk("t180_nb", 32'(new_best), 32'd1);
    trial(300); chk("t300_nb", 32'(new_best), 32'd0);
    chk("three_last", 32'(last_ms), 32'd300);
    chk("three_best", 32'(best_ms), 32'd180);
    chk("three_cnt",  32'(trial_cnt), 32'd3);
    chk("three_avgv", 32'(avg_valid), 32'd0);
    idle();

    // Tie with best must not pulse.
    trial(180); chk("tie_nb", 32'(new_best), 32'd0);

    // Rejections: false start and out-of-range; boundary 999 accepted.
    step(1'b0, 1'b1, 50, 1'b1, 1'b0, 1'b0);
    trial(1000);
    chk("rej_fault", 32'(fault_cnt), 32'd2);
    chk("rej_best",  32'(best_ms),   32'd180);
    chk("rej_last",  32'(last_ms),   32'd180);
    trial(999); chk("max_last", 32'(last_ms), 32'd999);

    // Average over four, then wrap.
    do_clear();
    trial(100); trial(200); trial(300); trial(400);
    chk("avg4", 32'(avg_ms), 32'd250);
    chk("avg4_v", 32'(avg_valid), 32'd1);
    trial(500);
    chk("avg_wrap", 32'(avg_ms), 32'd350);

    // Display cycling with seven trials, last=300.
    do_clear();
    for (int i = 0; i < 7; i++) trial(300);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1); chk("sel1", 32'(disp_sel), 32'd1);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1); chk("sel2", 32'(disp_sel), 32'd2);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1); chk("sel3_ms", 32'(disp_ms), 32'd7);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1); chk("sel0_ms", 32'(disp_ms), 32'd300);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1); chk("sel_wrap", 32'(disp_sel), 32'd1);

    // Clear wins over a coincident result; sel_next still steps.
    step(1'b0, 1'b1, 50, 1'b0, 1'b1, 1'b1);
    chk("clr_nb",   32'(new_best),  32'd0);
    chk("clr_bv",   32'(best_valid), 32'd0);
    chk("clr_sel",  32'(disp_sel),  32'd2);

    // Held result_valid: N cycles are N trials; sel_next with result.
    step(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 259; i++) trial(600);
    chk("sat_trial", 32'(trial_cnt), 32'd255);
    for (int i = 0; i < 258; i++) step(1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0);
    chk("sat_fault", 32'(fault_cnt), 32'd255);

    // Reset mid-operation drops the concurrent result.
    step(1'b1, 1'b1, 20, 1'b0, 1'b0, 1'b0);
    chk("midrst_cnt", 32'(trial_cnt), 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      r   = int'($urandom_range(0, 99));
      v   = (r < 70);
      err = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 5))
        0:       ms = 999;
        1:       ms = 1000;
        default: ms = int'($urandom_range(0, 1100));
      endcase
      clr = ($urandom_range(0, 39) == 0);
      sel = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 149) == 0);
      step(rst, v, ms, err, clr, sel);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
